param_controller: RTL and testbench
===================================

Name: param_controller

Overview:
- Parametrised multi-cycle instruction sequencer for the processor family, generalised in data width (W) and register count (NREG).
- Captures an instruction through a START/READY handshake and steps timesteps T1..T3.
- Drives register-file, ALU and external-input enables.
- Beyond the fixed 10-bit controller, it adds:
  - logical ALU ops;
  - a HALT instruction;
  - a sticky illegal-opcode flag;
  - a retired-instruction counter;
  - zero-gap back-to-back issue.

Parameters:
- W, 10, instruction/data width; elaboration error unless W >= 4+2*RAW.
- NREG, 4, number of registers; localparam RAW = $clog2(NREG).
- CNTW, 8, width of the retired-instruction counter.

Ports:
- CLKb  in  1  debounced system clock, rising edge.
- CLR  in  1  synchronous active-high reset.
- START  in  1  request to issue INSTR; sampled only when READY=1.
- INSTR  in  W  instruction word.
  - [W-1:W-4] opcode.
  - [W-5:W-4-RAW] Rx.
  - next RAW bits Ry.
  - remaining bits ignored.
- READY  out  1  high when a new instruction can be accepted.
- Ext  out  1  external D drives the bus.
- Rin  out  RAW  register write address.
- Rout  out  RAW  register read address.
- ENW  out  1  register write enable.
- ENR  out  1  register read-to-bus enable.
- Ain  out  1  ALU A-latch load.
- Gin  out  1  ALU G-latch load.
- Gout  out  1  G drives the bus.
- ALUcont  out  3  ALU function.
- T  out  2  current timestep; 0 when idle or halted.
- DONE  out  1  final step of the current instruction.
- HALTED  out  1  halt state.
- ILLEGAL  out  1  sticky illegal-opcode flag.
- ICNT  out  CNTW  retired-instruction count.

Behaviour:
- States: IDLE, S1, S2, S3, HALT.
- Control outputs are a combinational (Moore) decode of the state and the internal IR register.
  - Any step not listed below drives every enable 0, Rin/Rout 0 and ALUcont 0.
- READY = !HALTED && (state==IDLE || DONE).
  - Issue happens on an edge with START && READY: INSTR is latched into IR and the next state is S1.
  - Issue during the DONE cycle gives zero-gap back-to-back execution.
- DONE without issue: the next state is IDLE, or HALT for the HALT opcode.
- LOAD 0000:
  - S1: Ext=1, Rin=Rx, ENW=1, DONE=1.
- COPY 0001:
  - S1: Rout=Ry, ENR=1, Rin=Rx, ENW=1, DONE=1.
- Binary ALU ops (ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110):
  - S1: Rout=Rx, ENR=1, Ain=1.
  - S2: Rout=Ry, ENR=1, Gin=1, ALUcont=op.
  - S3: Gout=1, Rin=Rx, ENW=1, DONE=1.
- NOT 0111:
  - S1: Rout=Rx, ENR=1, Ain=1.
  - S2: Gin=1, ALUcont=NOT, bus not driven.
  - S3: same as the binary ops.
- HALT 1111:
  - S1: DONE=1; the next state is HALT.
  - In HALT: HALTED=1, READY=0, START ignored. Only CLR exits.
- Opcodes 1000-1110:
  - S1: DONE=1, no enables.
  - ILLEGAL is set on that edge and holds until CLR.
- T encoding: S1=1, S2=2, S3=3, IDLE/HALT=0.
- ICNT increments on every edge where DONE=1, including HALT and illegal opcodes.
  - Wraps modulo 2^CNTW.
- CLR has priority over everything, in any state including mid-instruction:
  - next state IDLE;
  - IR, ICNT, ILLEGAL, HALTED cleared to 0;
  - no enable asserted in the cycle after reset;
  - READY=1 once out of reset.
- START while READY=0 is ignored; it is not queued.
- INSTR changes after issue have no effect.

Decomposition:
- Package proc_pkg holds:
  - opcode enum: LOAD, COPY, ADD, SUB, AND, OR, XOR, NOT, HALT.
  - ALU function enum:
    - ADD=000, SUB=001, AND=010, OR=011
    - XOR=100, NOT=101
  - state enum.
  - field-offset localparam functions of W and NREG.
- One sub-module, op_decode:
  - combinational: opcode → op class (move, alu2, alu1, halt, illegal) and ALUcont.
  - instantiated inside param_controller.

Test Plan:
- Reset: CLR=1 for 2 cycles, then 0 → READY=1, T=0, all enables 0, ICNT=0, ILLEGAL=0, HALTED=0.
- LOAD R2: INSTR=10'b0000_10_00_00, START pulse → next cycle T=1, Ext=1, Rin=2, ENW=1, DONE=1; then idle with ICNT=1.
- ADD R1,R3: INSTR=10'b0010_01_11_00 → in order:
  - T1: Rout=1, ENR, Ain.
  - T2: Rout=3, ENR, Gin, ALUcont=000.
  - T3: Gout, Rin=1, ENW, DONE.
- Back-to-back: START held high, COPY R0,R1 then SUB R2,R0 → SUB S1 directly follows the COPY DONE cycle with no idle gap; ICNT=2 after SUB DONE.
- Illegal 1010_00_00_00 → one cycle with DONE=1 and no ENW; ILLEGAL=1 and stays 1 through a following LOAD until CLR.
- HALT, then START with LOAD → HALTED=1, READY=0, LOAD never issued.
- CLR asserted in S2 of an XOR → next cycle IDLE with all enables 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types for the parametrised instruction sequencer: opcodes, ALU functions,
// sequencer states, op classes and instruction field offsets.
package proc_pkg;

   typedef enum logic [3:0] {
      OP_LOAD = 4'b0000,
      OP_COPY = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SUB  = 4'b0011,
      OP_AND  = 4'b0100,
      OP_OR   = 4'b0101,
      OP_XOR  = 4'b0110,
      OP_NOT  = 4'b0111,
      OP_HALT = 4'b1111
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_NOT = 3'b101
   } alu_fn_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_S1,
      ST_S2,
      ST_S3,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CL_MOVE,
      CL_ALU2,
      CL_ALU1,
      CL_HALT,
      CL_ILLEGAL
   } op_class_e;

   localparam int OPW = 4;

   function automatic int raw_bits(int nreg);
      return $clog2(nreg);
   endfunction

   function automatic int opc_lsb(int w);
      return w - OPW;
   endfunction

   function automatic int rx_lsb(int w, int nreg);
      return w - OPW - raw_bits(nreg);
   endfunction

   // Lowest instruction bit the sequencer cares about; anything below is ignored.
   function automatic int ry_lsb(int w, int nreg);
      return w - OPW - 2 * raw_bits(nreg);
   endfunction

endpackage

// File: rtl/op_decode.sv
// Opcode classifier: maps a 4-bit opcode to its execution class and ALU function.
module op_decode
   import proc_pkg::*;
(
   input  logic [3:0] opcode_i,
   output logic [2:0] class_o,
   output logic [2:0] alu_fn_o
);

   always_comb begin
      class_o  = CL_ILLEGAL;
      alu_fn_o = ALU_ADD;
      case (opcode_i)
         OP_LOAD, OP_COPY: class_o = CL_MOVE;
         OP_ADD: begin class_o = CL_ALU2; alu_fn_o = ALU_ADD; end
         OP_SUB: begin class_o = CL_ALU2; alu_fn_o = ALU_SUB; end
         OP_AND: begin class_o = CL_ALU2; alu_fn_o = ALU_AND; end
         OP_OR:  begin class_o = CL_ALU2; alu_fn_o = ALU_OR;  end
         OP_XOR: begin class_o = CL_ALU2; alu_fn_o = ALU_XOR; end
         OP_NOT: begin class_o = CL_ALU1; alu_fn_o = ALU_NOT; end
         OP_HALT: class_o = CL_HALT;
         default: ;
      endcase
   end

endmodule

// File: rtl/param_controller.sv
// Multi-cycle instruction sequencer: START/READY issue, T1..T3 stepping, Moore decode
// of register-file / ALU / external-input enables, with halt, illegal flag and retire count.
module param_controller
   import proc_pkg::*;
#(
   parameter  int W    = 10,
   parameter  int NREG = 4,
   parameter  int CNTW = 8,
   localparam int RAW  = $clog2(NREG)
) (
   input  logic            CLKb,
   input  logic            CLR,
   input  logic            START,
   input  logic [W-1:0]    INSTR,
   output logic            READY,
   output logic            Ext,
   output logic [RAW-1:0]  Rin,
   output logic [RAW-1:0]  Rout,
   output logic            ENW,
   output logic            ENR,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic [2:0]      ALUcont,
   output logic [1:0]      T,
   output logic            DONE,
   output logic            HALTED,
   output logic            ILLEGAL,
   output logic [CNTW-1:0] ICNT
);

   localparam int IRW = OPW + 2 * RAW;

   generate
      if (NREG < 2 || W < OPW + 2 * RAW) begin : g_param_err
         $error("param_controller: W must be >= 4+2*clog2(NREG) and NREG >= 2");
      end
   endgenerate

   state_e          state_q, state_d;
   logic [IRW-1:0]  ir_q;
   logic [CNTW-1:0] icnt_q;
   logic            illegal_q;
   logic [2:0]      cls;
   logic [2:0]      alu_fn;
   logic [RAW-1:0]  rx, ry;
   logic            issue;
   logic            unused_instr;

   // Only opcode/Rx/Ry are kept; trailing instruction bits are don't-care.
   assign unused_instr = ^INSTR;
   assign rx = ir_q[RAW +: RAW];
   assign ry = ir_q[0 +: RAW];

   op_decode u_dec (
      .opcode_i (ir_q[IRW-1 -: OPW]),
      .class_o  (cls),
      .alu_fn_o (alu_fn)
   );

   always_comb begin
      state_d = state_q;
      Ext     = 1'b0;
      Rin     = '0;
      Rout    = '0;
      ENW     = 1'b0;
      ENR     = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      ALUcont = 3'b000;
      T       = 2'd0;
      DONE    = 1'b0;
      case (state_q)
         ST_S1: begin
            T = 2'd1;
            case (cls)
               CL_MOVE: begin
                  Rin  = rx;
                  ENW  = 1'b1;
                  DONE = 1'b1;
                  // opcode bit 0 separates COPY (register source) from LOAD (external)
                  if (ir_q[IRW-OPW]) begin
                     Rout = ry;
                     ENR  = 1'b1;
                  end else begin
                     Ext = 1'b1;
                  end
               end
               CL_ALU2, CL_ALU1: begin
                  Rout = rx;
                  ENR  = 1'b1;
                  Ain  = 1'b1;
               end
               default: DONE = 1'b1;
            endcase
         end
         ST_S2: begin
            T       = 2'd2;
            Gin     = 1'b1;
            ALUcont = alu_fn;
            if (cls == CL_ALU2) begin
               Rout = ry;
               ENR  = 1'b1;
            end
         end
         ST_S3: begin
            T    = 2'd3;
            Gout = 1'b1;
            Rin  = rx;
            ENW  = 1'b1;
            DONE = 1'b1;
         end
         default: ;
      endcase

      HALTED = (state_q == ST_HALT);
      READY  = !HALTED && (state_q == ST_IDLE || DONE);
      issue  = START && READY;

      if (issue)
         state_d = ST_S1;
      else if (DONE)
         state_d = (cls == CL_HALT) ? ST_HALT : ST_IDLE;
      else if (state_q == ST_S1)
         state_d = ST_S2;
      else if (state_q == ST_S2)
         state_d = ST_S3;
   end

   always_ff @(posedge CLKb) begin
      if (CLR) begin
         state_q   <= ST_IDLE;
         ir_q      <= '0;
         icnt_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (issue)
            ir_q <= INSTR[W-1 : ry_lsb(W, NREG)];
         if (DONE)
            icnt_q <= icnt_q + 1'b1;
         if (DONE && cls == CL_ILLEGAL)
            illegal_q <= 1'b1;
      end
   end

   assign ILLEGAL = illegal_q;
   assign ICNT    = icnt_q;

endmodule

// File: tb/tb_param_controller.sv
// Bench for param_controller: per-instruction step-list reference model compared every
// cycle, plus directed scenarios with literal expectations and a randomized phase.
module tb_param_controller;

   localparam int W    = 10;
   localparam int NREG = 4;
   localparam int CNTW = 8;
   localparam int RAW  = 2;

   logic            clk = 1'b0;
   logic            CLR, START;
   logic [W-1:0]    INSTR;
   logic            READY, Ext, ENW, ENR, Ain, Gin, Gout, DONE, HALTED, ILLEGAL;
   logic [RAW-1:0]  Rin, Rout;
   logic [2:0]      ALUcont;
   logic [1:0]      T;
   logic [CNTW-1:0] ICNT;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   param_controller #(.W(W), .NREG(NREG), .CNTW(CNTW)) dut (
      .CLKb(clk), .CLR(CLR), .START(START), .INSTR(INSTR), .READY(READY), .Ext(Ext),
      .Rin(Rin), .Rout(Rout), .ENW(ENW), .ENR(ENR), .Ain(Ain), .Gin(Gin), .Gout(Gout),
      .ALUcont(ALUcont), .T(T), .DONE(DONE), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .ICNT(ICNT)
   );

   // One entry per timestep of an instruction; hlt/ill are model-only side effects.
   typedef struct {
      logic           ext, enw, enr, ain, gin, gout, done, hlt, ill;
      logic [RAW-1:0] rin, rout;
      logic [2:0]     alu;
      logic [1:0]     t;
   } step_t;

   step_t           q[$];
   logic [CNTW-1:0] m_icnt = '0;
   logic            m_ill  = 1'b0;
   logic            m_halt = 1'b0;
   bit              m_en   = 1'b0;

   function automatic step_t blank(int t);
      step_t s;
      s = '{default: 0};
      s.t = 2'(t);
      return s;
   endfunction

   function automatic void load_steps(logic [W-1:0] ins);
      logic [3:0]     op;
      logic [RAW-1:0] rx, ry;
      step_t          s;
      op = ins[W-1 -: 4];
      rx = ins[W-5 -: RAW];
      ry = ins[W-5-RAW -: RAW];
      q.delete();
      if (op == 4'd0) begin
         s = blank(1); s.ext = 1; s.rin = rx; s.enw = 1; s.done = 1; q.push_back(s);
      end else if (op == 4'd1) begin
         s = blank(1); s.rout = ry; s.enr = 1; s.rin = rx; s.enw = 1; s.done = 1; q.push_back(s);
      end else if (op <= 4'd7) begin
         s = blank(1); s.rout = rx; s.enr = 1; s.ain = 1; q.push_back(s);
         s = blank(2); s.gin = 1;
         if (op == 4'd7) s.alu = 3'd5;
         else begin s.alu = 3'(op - 4'd2); s.rout = ry; s.enr = 1; end
         q.push_back(s);
         s = blank(3); s.gout = 1; s.rin = rx; s.enw = 1; s.done = 1; q.push_back(s);
      end else begin
         s = blank(1); s.done = 1;
         if (op == 4'hF) s.hlt = 1; else s.ill = 1;
         q.push_back(s);
      end
   endfunction

   function automatic logic [26:0] expected();
      step_t cur;
      logic  rdy;
      cur = (q.size() != 0) ? q[0] : blank(0);
      rdy = !m_halt && (q.size() == 0 || cur.done);
      return {rdy, cur.ext, cur.rin, cur.rout, cur.enw, cur.enr, cur.ain, cur.gin, cur.gout,
              cur.alu, cur.t, cur.done, m_halt, m_ill, m_icnt};
   endfunction

   always @(posedge clk) begin : model
      step_t cur;
      logic  rdy;
      if (CLR) begin
         q.delete();
         m_icnt = '0;
         m_ill  = 1'b0;
         m_halt = 1'b0;
         m_en   = 1'b1;
      end else if (m_en) begin
         cur = (q.size() != 0) ? q[0] : blank(0);
         rdy = !m_halt && (q.size() == 0 || cur.done);
         if (cur.done) begin
            m_icnt = m_icnt + 1'b1;
            if (cur.ill) m_ill = 1'b1;
         end
         if (START && rdy) load_steps(INSTR);
         else if (q.size() != 0) begin
            void'(q.pop_front());
            if (cur.done && cur.hlt) m_halt = 1'b1;
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [26:0] act, exp;
      if (m_en) begin
         act = {READY, Ext, Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont, T, DONE,
                HALTED, ILLEGAL, ICNT};
         exp = expected();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp @%0t: got %h expected %h", $time, act, exp);
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      CLR   = 1'b1;
      START = 1'b0;
      step();
      step();
      CLR = 1'b0;
   endtask

   initial begin
      CLR = 1'b1; START = 1'b0; INSTR = '0;
      do_reset();
      chk("rst_ready", READY, 1);     chk("rst_t", T, 0);
      chk("rst_enw", ENW, 0);         chk("rst_icnt", ICNT, 0);
      chk("rst_illegal", ILLEGAL, 0); chk("rst_halted", HALTED, 0);

      // LOAD R2
      INSTR = 10'b0000_10_00_00; START = 1'b1; step(); START = 1'b0;
      chk("load_t", T, 1); chk("load_ext", Ext, 1); chk("load_rin", Rin, 2);
      chk("load_enw", ENW, 1); chk("load_done", DONE, 1);
      step();
      chk("load_idle_t", T, 0); chk("load_icnt", ICNT, 1);

      // ADD R1,R3
      INSTR = 10'b0010_01_11_00; START = 1'b1; step(); START = 1'b0;
      chk("add_t1_rout", Rout, 1); chk("add_t1_enr", ENR, 1); chk("add_t1_ain", Ain, 1);
      step();
      chk("add_t2_rout", Rout, 3); chk("add_t2_gin", Gin, 1); chk("add_t2_alu", ALUcont, 0);
      step();
      chk("add_t3_gout", Gout, 1); chk("add_t3_rin", Rin, 1); chk("add_t3_done", DONE, 1);
      step();
      chk("add_icnt", ICNT, 2);

      // Back-to-back COPY R0,R1 then SUB R2,R0
      do_reset();
      INSTR = 10'b0001_00_01_00; START = 1'b1; step();
      chk("copy_rout", Rout, 1); chk("copy_done", DONE, 1); chk("copy_ready", READY, 1);
      INSTR = 10'b0011_10_00_00; step(); START = 1'b0;
      chk("b2b_sub_t", T, 1); chk("b2b_sub_rout", Rout, 2); chk("b2b_sub_ain", Ain, 1);
      step();
      chk("sub_alu", ALUcont, 1);
      step(); step();
      chk("b2b_icnt", ICNT, 2); chk("b2b_idle_t", T, 0);

      // Illegal opcode, sticky through a following LOAD
      do_reset();
      INSTR = 10'b1010_00_00_00; START = 1'b1; step(); START = 1'b0;
      chk("ill_done", DONE, 1); chk("ill_enw", ENW, 0);
      step();
      chk("ill_flag", ILLEGAL, 1);
      INSTR = 10'b0000_01_00_00; START = 1'b1; step(); START = 1'b0;
      step();
      chk("ill_sticky", ILLEGAL, 1); chk("ill_icnt", ICNT, 2);
      do_reset();
      chk("ill_cleared", ILLEGAL, 0);

      // HALT, then a START that must be ignored
      INSTR = 10'b1111_00_00_00; START = 1'b1; step(); START = 1'b0;
      chk("halt_done", DONE, 1);
      step();
      chk("halted", HALTED, 1); chk("halt_ready", READY, 0);
      INSTR = 10'b0000_11_00_00; START = 1'b1; step(); step(); START = 1'b0;
      chk("halt_still", HALTED, 1); chk("halt_no_enw", ENW, 0); chk("halt_icnt", ICNT, 1);
      do_reset();
      chk("halt_exit", HALTED, 0);

      // CLR in S2 of XOR R1,R2
      INSTR = 10'b0110_01_10_00; START = 1'b1; step(); START = 1'b0;
      step();
      chk("xor_t2_alu", ALUcont, 4); chk("xor_t2_rout", Rout, 2);
      CLR = 1'b1; step(); CLR = 1'b0;
      chk("clr_mid_t", T, 0); chk("clr_mid_enr", ENR, 0);
      chk("clr_mid_gin", Gin, 0); chk("clr_mid_ready", READY, 1);

      // Randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         int sel;
         CLR   = ($urandom_range(0, 39) == 0);
         START = $urandom_range(0, 1);
         sel   = $urandom_range(0, 9);
         INSTR = W'($urandom);
         if (sel <= 7)      INSTR[W-1 -: 4] = 4'(sel);
         else if (sel == 8) INSTR[W-1 -: 4] = 4'hF;
         else               INSTR[W-1 -: 4] = 4'($urandom_range(8, 14));
         step();
      end

      CLR = 1'b0; START = 1'b0;
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
